// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory-path sequencer for the LC-3b core, arbitrating instruction fetch against
// data/TRAP accesses and producing Moore-decoded datapath strobes and completion acks.
module mem_access_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter bit FAIR     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_f,
    input  logic req_d,
    input  logic req_d_we,
    input  logic req_d_byte,
    input  logic req_d_trap,
    input  logic mem_r,
    output logic ld_mar,
    output logic mar_sel,
    output logic gate_pc,
    output logic mem_en,
    output logic mem_we,
    output logic mem_byte,
    output logic ld_mdr,
    output logic ack_f,
    output logic ack_d,
    output logic err
);

    typedef enum logic [2:0] {StIdle, StLdMar, StAccess, StLdMdr, StDone} state_e;
    typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

    // Counter only needs to reach MAX_WAIT-1 before the timeout decision is taken.
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic            byte_q, byte_d;
    logic            trap_q, trap_d;
    logic            last_data_q, last_data_d;
    logic            tmo_q, tmo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            grant_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OwnNone;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            trap_q      <= 1'b0;
            last_data_q <= 1'b1;
            tmo_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            trap_q      <= trap_d;
            last_data_q <= last_data_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        byte_d      = byte_q;
        trap_d      = trap_q;
        last_data_d = last_data_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        grant_data  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_f || req_d) begin
                    // Contention: round-robin against the last grant, or data priority.
                    grant_data = req_d && (!req_f || !FAIR || !last_data_q);
                    owner_d    = grant_data ? OwnData : OwnFetch;
                    we_d       = grant_data && req_d_we;
                    byte_d     = grant_data && req_d_byte;
                    trap_d     = grant_data && req_d_trap;
                    tmo_d      = 1'b0;
                    state_d    = StLdMar;
                end
            end
            StLdMar: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (mem_r) begin
                    state_d = (we_q && !trap_q) ? StDone : StLdMdr;
                end else if (MAX_WAIT > 0 && cnt_q == WaitLast) begin
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLdMdr: begin
                state_d = StDone;
            end
            StDone: begin
                last_data_d = (owner_q == OwnData);
                owner_d     = OwnNone;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ld_mar   = 1'b0;
        mar_sel  = 1'b0;
        gate_pc  = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_byte = 1'b0;
        ld_mdr   = 1'b0;
        ack_f    = 1'b0;
        ack_d    = 1'b0;
        err      = 1'b0;
        case (state_q)
            StLdMar: begin
                ld_mar  = 1'b1;
                gate_pc = (owner_q == OwnFetch);
                mar_sel = (owner_q == OwnData) && trap_q;
            end
            StAccess: begin
                mem_en   = 1'b1;
                mem_we   = we_q && !trap_q;
                mem_byte = byte_q && !trap_q;
            end
            StLdMdr: begin
                // Byte qualifier stays with the memory cycle while the read data is captured.
                mem_en   = 1'b1;
                mem_byte = byte_q && !trap_q;
                ld_mdr   = 1'b1;
            end
            StDone: begin
                ack_f = (owner_q == OwnFetch);
                ack_d = (owner_q == OwnData);
                err   = tmo_q;
            end
            default: begin
            end
        endcase
    end

endmodule
